mem_dados_param: RTL and testbench

//  Parametrised successor data memory for the processor datapath: byte/half/word access,

---
 rtl/mem_dados_pkg.sv | 25 ++
 rtl/mem_dados_param_if.sv | 27 ++
 rtl/mem_dados_alinhador.sv | 67 ++++++
 rtl/mem_dados_param.sv | 140 ++++++++++++++
 tb/tb_mem_dados_param.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_dados_pkg.sv
// Shared definitions for the data memory: access size codes, FSM state
// encoding and the index-width helper.
package mem_dados_pkg;

  typedef enum logic [1:0] {
    TAM_BYTE      = 2'b00,
    TAM_MEIA      = 2'b01,
    TAM_PALAVRA   = 2'b10,
    TAM_RESERVADO = 2'b11
  } tamanho_t;

  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    ESPERA   = 2'b01,
    RESPONDE = 2'b10
  } estado_t;

  localparam int LARGURA_CONTADOR = 4;

  // Number of word-index bits needed to address a memory of the given depth.
  function automatic int largura_indice(input int profundidade);
    return $clog2(profundidade);
  endfunction

endpackage

// File: rtl/mem_dados_param_if.sv
// Load/store request bus between the pipeline stage and the data memory.
import mem_dados_pkg::*;

interface mem_dados_param_if #(
  parameter int LARGURA_END = 32
);
  logic                   req;
  logic                   escrita;
  tamanho_t               tamanho;
  logic                   sem_sinal;
  logic [LARGURA_END-1:0] endereco;
  logic [31:0]            valor_escrita;
  logic                   pronto;
  logic                   valido;
  logic [31:0]            dado_saida;
  logic                   erro_alinh;

  modport master (
    output req, escrita, tamanho, sem_sinal, endereco, valor_escrita,
    input  pronto, valido, dado_saida, erro_alinh
  );

  modport slave (
    input  req, escrita, tamanho, sem_sinal, endereco, valor_escrita,
    output pronto, valido, dado_saida, erro_alinh
  );
endinterface

// File: rtl/mem_dados_alinhador.sv
// Combinational lane logic: alignment check, byte-enable mask, store data
// replication and load extraction with sign/zero extension.
import mem_dados_pkg::*;

module mem_dados_alinhador (
  input  tamanho_t    tamanho,
  input  logic        sem_sinal,
  input  logic [1:0]  lane,
  input  logic [31:0] valor_escrita,
  input  logic [31:0] palavra_lida,
  output logic        erro,
  output logic [3:0]  mascara,
  output logic [31:0] dado_escrita,
  output logic [31:0] dado_carga
);

  logic [7:0]  byte_sel;
  logic [15:0] meia_sel;

  // Select the addressed byte and half from the stored word.
  always_comb begin
    byte_sel = palavra_lida[7:0];
    case (lane)
      2'd0:    byte_sel = palavra_lida[7:0];
      2'd1:    byte_sel = palavra_lida[15:8];
      2'd2:    byte_sel = palavra_lida[23:16];
      default: byte_sel = palavra_lida[31:24];
    endcase
    meia_sel = lane[1] ? palavra_lida[31:16] : palavra_lida[15:0];
  end

  // Decode size/lane into error, write mask, replicated store data and load result.
  always_comb begin
    erro         = 1'b0;
    mascara      = 4'b0000;
    dado_escrita = 32'd0;
    dado_carga   = 32'd0;
    case (tamanho)
      TAM_BYTE: begin
        mascara      = 4'b0001 << lane;
        dado_escrita = {4{valor_escrita[7:0]}};
        dado_carga   = sem_sinal ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      TAM_MEIA: begin
        erro         = lane[0];
        mascara      = lane[1] ? 4'b1100 : 4'b0011;
        dado_escrita = {2{valor_escrita[15:0]}};
        dado_carga   = sem_sinal ? {16'd0, meia_sel} : {{16{meia_sel[15]}}, meia_sel};
      end
      TAM_PALAVRA: begin
        erro         = |lane;
        mascara      = 4'b1111;
        dado_escrita = valor_escrita;
        dado_carga   = palavra_lida;
      end
      default: begin
        erro = 1'b1;
      end
    endcase
    // A rejected access must neither touch the array nor return data.
    if (erro) begin
      mascara    = 4'b0000;
      dado_carga = 32'd0;
    end
  end

endmodule

// File: rtl/mem_dados_param.sv
// Word-organised data memory with byte/half/word access and a configurable
// number of wait states between accept and response.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  OCIOSO   | idle, pronto=1, a request is accepted on req
//  ESPERA   | wait states, counter counts down to 0
//  RESPONDE | array access; store commits and response is registered at
//           | the edge leaving this state
import mem_dados_pkg::*;

module mem_dados_param #(
  parameter int PROFUNDIDADE = 64,
  parameter int LARGURA_END  = 32,
  parameter int LATENCIA     = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  mem_dados_param_if.slave  bus
);

  localparam int IW = largura_indice(PROFUNDIDADE);
  localparam logic [LARGURA_CONTADOR-1:0] CONT_INI =
    (LATENCIA > 0) ? LARGURA_CONTADOR'(LATENCIA - 1) : '0;

  estado_t                     estado;
  logic [LARGURA_CONTADOR-1:0] contador;

  logic        cap_escrita;
  tamanho_t    cap_tamanho;
  logic        cap_sem_sinal;
  logic [IW+1:0] cap_endereco;
  logic [31:0] cap_valor;

  logic        pronto_q;
  logic        valido_q;
  logic [31:0] dado_q;
  logic        erro_q;

  logic [31:0] memoria [0:PROFUNDIDADE-1];

  logic [IW-1:0] indice;
  logic [1:0]    lane;
  logic [31:0]   palavra_lida;
  logic          erro;
  logic [3:0]    mascara;
  logic [31:0]   dado_escrita;
  logic [31:0]   dado_carga;

  // Upper address bits beyond the array are dropped at capture, so addresses wrap.
  assign indice       = cap_endereco[IW+1:2];
  assign lane         = cap_endereco[1:0];
  assign palavra_lida = memoria[indice];

  mem_dados_alinhador u_alinhador (
    .tamanho       (cap_tamanho),
    .sem_sinal     (cap_sem_sinal),
    .lane          (lane),
    .valor_escrita (cap_valor),
    .palavra_lida  (palavra_lida),
    .erro          (erro),
    .mascara       (mascara),
    .dado_escrita  (dado_escrita),
    .dado_carga    (dado_carga)
  );

  // Control FSM with wait-state down-counter, request capture and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado        <= OCIOSO;
      contador      <= '0;
      cap_escrita   <= 1'b0;
      cap_tamanho   <= TAM_BYTE;
      cap_sem_sinal <= 1'b0;
      cap_endereco  <= '0;
      cap_valor     <= 32'd0;
      pronto_q      <= 1'b1;
      valido_q      <= 1'b0;
      dado_q        <= 32'd0;
      erro_q        <= 1'b0;
    end else begin
      valido_q <= 1'b0;
      dado_q   <= 32'd0;
      erro_q   <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (bus.req && pronto_q) begin
            cap_escrita   <= bus.escrita;
            cap_tamanho   <= bus.tamanho;
            cap_sem_sinal <= bus.sem_sinal;
            cap_endereco  <= bus.endereco[IW+1:0];
            cap_valor     <= bus.valor_escrita;
            pronto_q      <= 1'b0;
            if (LATENCIA == 0) begin
              estado <= RESPONDE;
            end else begin
              estado   <= ESPERA;
              contador <= CONT_INI;
            end
          end
        end
        ESPERA: begin
          if (contador == '0) begin
            estado <= RESPONDE;
          end else begin
            contador <= contador - 1'b1;
          end
        end
        RESPONDE: begin
          estado   <= OCIOSO;
          pronto_q <= 1'b1;
          valido_q <= 1'b1;
          erro_q   <= erro;
          dado_q   <= (erro || cap_escrita) ? 32'd0 : dado_carga;
        end
        default: begin
          estado   <= OCIOSO;
          pronto_q <= 1'b1;
        end
      endcase
    end
  end

  // Byte-lane store at the edge leaving RESPONDE; a reset on that edge cancels it.
  always_ff @(posedge clock) begin
    if (reset_n && (estado == RESPONDE) && cap_escrita) begin
      for (int k = 0; k < 4; k++) begin
        if (mascara[k]) begin
          memoria[indice][8*k +: 8] <= dado_escrita[8*k +: 8];
        end
      end
    end
  end

  assign bus.pronto     = pronto_q;
  assign bus.valido     = valido_q;
  assign bus.dado_saida = dado_q;
  assign bus.erro_alinh = erro_q;

endmodule

// File: tb/tb_mem_dados_param.sv
// Directed bench: three builds (LATENCIA 0, 1, 3) sharing one stimulus bus,
// with a selector routing req and responses to the build under test.
import mem_dados_pkg::*;

module tb_mem_dados_param;

  logic clock;
  logic reset_n;

  logic        req_t;
  logic        escrita_t;
  logic [1:0]  tam_t;
  logic        sem_t;
  logic [31:0] end_t;
  logic [31:0] val_t;
  int          sel;

  logic        pronto_m;
  logic        valido_m;
  logic [31:0] dado_m;
  logic        erro_m;

  int total;
  int bad;

  mem_dados_param_if #(.LARGURA_END(32)) bus0 ();
  mem_dados_param_if #(.LARGURA_END(32)) bus1 ();
  mem_dados_param_if #(.LARGURA_END(32)) bus3 ();

  assign bus0.req = req_t && (sel == 0);
  assign bus1.req = req_t && (sel == 1);
  assign bus3.req = req_t && (sel == 3);
  assign bus0.escrita = escrita_t;
  assign bus1.escrita = escrita_t;
  assign bus3.escrita = escrita_t;
  assign bus0.tamanho = tamanho_t'(tam_t);
  assign bus1.tamanho = tamanho_t'(tam_t);
  assign bus3.tamanho = tamanho_t'(tam_t);
  assign bus0.sem_sinal = sem_t;
  assign bus1.sem_sinal = sem_t;
  assign bus3.sem_sinal = sem_t;
  assign bus0.endereco = end_t;
  assign bus1.endereco = end_t;
  assign bus3.endereco = end_t;
  assign bus0.valor_escrita = val_t;
  assign bus1.valor_escrita = val_t;
  assign bus3.valor_escrita = val_t;

  always_comb begin
    pronto_m = bus1.pronto;
    valido_m = bus1.valido;
    dado_m   = bus1.dado_saida;
    erro_m   = bus1.erro_alinh;
    if (sel == 0) begin
      pronto_m = bus0.pronto;
      valido_m = bus0.valido;
      dado_m   = bus0.dado_saida;
      erro_m   = bus0.erro_alinh;
    end else if (sel == 3) begin
      pronto_m = bus3.pronto;
      valido_m = bus3.valido;
      dado_m   = bus3.dado_saida;
      erro_m   = bus3.erro_alinh;
    end
  end

  mem_dados_param #(.PROFUNDIDADE(64), .LARGURA_END(32), .LATENCIA(0)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .bus(bus0));
  mem_dados_param #(.PROFUNDIDADE(64), .LARGURA_END(32), .LATENCIA(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .bus(bus1));
  mem_dados_param #(.PROFUNDIDADE(64), .LARGURA_END(32), .LATENCIA(3)) u_dut3 (
    .clock(clock), .reset_n(reset_n), .bus(bus3));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        escrita;
    logic [1:0]  tam;
    logic        sem;
    logic [31:0] endereco;
    logic [31:0] valor;
    logic [31:0] exp_dado;
    logic        exp_erro;
  } vetor_t;

  vetor_t vet [24];

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", nome, got, exp);
    end
  endtask

  // One access: wait for pronto, hold req until accept, then count edges to valido.
  task automatic acesso(input logic e, input logic [1:0] tam, input logic s,
                        input logic [31:0] a, input logic [31:0] v,
                        output logic [31:0] d, output logic er, output int lat,
                        output logic pr);
    int guarda;
    bit visto;
    @(negedge clock);
    escrita_t = e; tam_t = tam; sem_t = s; end_t = a; val_t = v; req_t = 1'b1;
    guarda = 0;
    while (!pronto_m && guarda < 50) begin
      @(negedge clock);
      guarda++;
    end
    @(posedge clock);
    #1;
    req_t = 1'b0;
    lat = 0;
    visto = 0;
    while (!visto && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
      if (valido_m) visto = 1;
    end
    d  = dado_m;
    er = erro_m;
    pr = pronto_m;
    if (!visto) lat = -1;
  endtask

  task automatic acesso_chk(input string nome, input int lat_exp, input logic e,
                            input logic [1:0] tam, input logic s,
                            input logic [31:0] a, input logic [31:0] v,
                            input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] d;
    logic er;
    logic pr;
    int lat;
    acesso(e, tam, s, a, v, d, er, lat, pr);
    chk({nome, " latency"}, 32'(lat), 32'(lat_exp));
    chk({nome, " dado"}, d, exp_d);
    chk({nome, " erro"}, {31'd0, er}, {31'd0, exp_e});
    chk({nome, " pronto"}, {31'd0, pr}, 32'd1);
  endtask

  initial begin
    total = 0; bad = 0;
    req_t = 0; escrita_t = 0; tam_t = 2'b00; sem_t = 0; end_t = 0; val_t = 0;
    sel = 1;
    reset_n = 1'b0;

    vet[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    vet[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vet[2]  = '{1'b1, 2'b10, 1'b0, 32'h20,  32'h11223344, 32'h0,        1'b0};
    vet[3]  = '{1'b1, 2'b00, 1'b0, 32'h21,  32'hABCDEF80, 32'h0,        1'b0};
    vet[4]  = '{1'b0, 2'b00, 1'b0, 32'h21,  32'h0,        32'hFFFFFF80, 1'b0};
    vet[5]  = '{1'b0, 2'b00, 1'b1, 32'h21,  32'h0,        32'h00000080, 1'b0};
    vet[6]  = '{1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h11228044, 1'b0};
    vet[7]  = '{1'b0, 2'b01, 1'b0, 32'h13,  32'h0,        32'h0,        1'b1};
    vet[8]  = '{1'b1, 2'b01, 1'b0, 32'h13,  32'h0000AAAA, 32'h0,        1'b1};
    vet[9]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vet[10] = '{1'b1, 2'b10, 1'b0, 32'h0,   32'hCAFEF00D, 32'h0,        1'b0};
    vet[11] = '{1'b1, 2'b11, 1'b0, 32'h0,   32'hFFFFFFFF, 32'h0,        1'b1};
    vet[12] = '{1'b0, 2'b11, 1'b0, 32'h0,   32'h0,        32'h0,        1'b1};
    vet[13] = '{1'b0, 2'b10, 1'b0, 32'h0,   32'h0,        32'hCAFEF00D, 1'b0};
    vet[14] = '{1'b1, 2'b01, 1'b0, 32'h22,  32'h1234BEEF, 32'h0,        1'b0};
    vet[15] = '{1'b0, 2'b01, 1'b0, 32'h22,  32'h0,        32'hFFFFBEEF, 1'b0};
    vet[16] = '{1'b0, 2'b01, 1'b1, 32'h22,  32'h0,        32'h0000BEEF, 1'b0};
    vet[17] = '{1'b0, 2'b01, 1'b0, 32'h20,  32'h0,        32'hFFFF8044, 1'b0};
    vet[18] = '{1'b0, 2'b00, 1'b0, 32'h23,  32'h0,        32'hFFFFFFBE, 1'b0};
    vet[19] = '{1'b0, 2'b00, 1'b1, 32'h20,  32'h0,        32'h00000044, 1'b0};
    vet[20] = '{1'b0, 2'b10, 1'b0, 32'h22,  32'h0,        32'h0,        1'b1};
    vet[21] = '{1'b1, 2'b10, 1'b0, 32'h100, 32'h5A5A0001, 32'h0,        1'b0};
    vet[22] = '{1'b0, 2'b10, 1'b0, 32'h0,   32'h0,        32'h5A5A0001, 1'b0};
    vet[23] = '{1'b0, 2'b00, 1'b1, 32'h102, 32'h0,        32'h0000005A, 1'b0};

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("reset pronto", {31'd0, pronto_m}, 32'd1);
    chk("reset valido", {31'd0, valido_m}, 32'd0);
    chk("reset dado",   dado_m, 32'd0);
    chk("reset erro",   {31'd0, erro_m}, 32'd0);

    sel = 1;
    for (int i = 0; i < 24; i++) begin
      acesso_chk($sformatf("vec%0d", i), 2, vet[i].escrita, vet[i].tam, vet[i].sem,
                 vet[i].endereco, vet[i].valor, vet[i].exp_dado, vet[i].exp_erro);
    end

    sel = 0;
    acesso_chk("lat0 store", 1, 1'b1, 2'b10, 1'b0, 32'h4, 32'h01020304, 32'h0, 1'b0);
    acesso_chk("lat0 load",  1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h01020304, 1'b0);
    acesso_chk("lat0 byte",  1, 1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 32'h00000001, 1'b0);

    sel = 3;
    acesso_chk("lat3 store", 4, 1'b1, 2'b10, 1'b0, 32'h4, 32'hA1B2C3D4, 32'h0, 1'b0);
    acesso_chk("lat3 load",  4, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'hA1B2C3D4, 1'b0);

    // req kept high with store fields while the load waits: must be ignored.
    @(negedge clock);
    escrita_t = 1'b0; tam_t = 2'b10; sem_t = 1'b0; end_t = 32'h4; val_t = 32'h0; req_t = 1'b1;
    @(posedge clock);
    #1;
    escrita_t = 1'b1; val_t = 32'hFFFFFFFF;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clock);
      #1;
      chk($sformatf("hold%0d pronto", k), {31'd0, pronto_m}, 32'd0);
      chk($sformatf("hold%0d valido", k), {31'd0, valido_m}, 32'd0);
      chk($sformatf("hold%0d dado", k), dado_m, 32'd0);
    end
    @(posedge clock);
    #1;
    req_t = 1'b0;
    chk("hold resp valido", {31'd0, valido_m}, 32'd1);
    chk("hold resp dado", dado_m, 32'hA1B2C3D4);
    @(posedge clock);
    #1;
    chk("strobe one cycle", {31'd0, valido_m}, 32'd0);
    acesso_chk("hold no store", 4, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'hA1B2C3D4, 1'b0);

    // Reset during the wait states of a store: outputs reset, store dropped.
    acesso_chk("rst old store", 4, 1'b1, 2'b10, 1'b0, 32'h8, 32'h0BADF00D, 32'h0, 1'b0);
    @(negedge clock);
    escrita_t = 1'b1; tam_t = 2'b10; sem_t = 1'b0; end_t = 32'h8; val_t = 32'h12345678; req_t = 1'b1;
    @(posedge clock);
    #1;
    req_t = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    chk("midrst pronto", {31'd0, pronto_m}, 32'd1);
    chk("midrst valido", {31'd0, valido_m}, 32'd0);
    chk("midrst dado",   dado_m, 32'd0);
    chk("midrst erro",   {31'd0, erro_m}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock);
      #1;
      chk($sformatf("postrst%0d valido", k), {31'd0, valido_m}, 32'd0);
    end
    acesso_chk("rst old kept", 4, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h0BADF00D, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
